adc_level_trigger: RTL
======================

Name: adc_level_trigger

Overview:
- Generates the single-cycle `trig` pulse that starts the BRAM capture address counter in the adc-dac-bram design.
- Watches the ADC sample stream for a level crossing with hysteresis, edge selection and holdoff.
- Supports single-shot and auto-rearm modes, plus software force.
- Sits between the ADC sample register and the address counter; same `clk`/`clken` domain.

Parameters:
- ADC_WIDTH, 16, signed ADC sample width.
- HOLDOFF_WIDTH, 16, holdoff counter width.
- TS_WIDTH, 48, timestamp width (optional feature only).

Ports:
- clk  in  1  sample clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- clken  in  1  clock enable; all state advances only when high.
- adc_data  in  ADC_WIDTH  signed sample.
- level  in  ADC_WIDTH  signed trigger threshold.
- hysteresis  in  ADC_WIDTH-1  unsigned hysteresis band.
- edge  in  1  0 = rising, 1 = falling.
- mode  in  2  0 = off, 1 = single, 2 = normal (auto-rearm), 3 = reserved (treated as 0).
- arm  in  1  pulse; arms in single mode.
- force_trig  in  1  pulse; software trigger.
- holdoff  in  HOLDOFF_WIDTH  rearm delay in clken cycles (normal mode).
- trig  out  1  one-cycle trigger pulse to the address counter.
- armed  out  1  high in ARMED.
- trig_count  out  32  triggers issued, wraps.

Behaviour:
- Reset (async, resetn = 0):
  - State IDLE; `trig`, `armed` = 0; `trig_count` = 0.
  - Pre-condition flag, holdoff counter and sample register cleared.
- Pipeline:
  - `adc_data` is registered on a clken edge N.
  - Compare happens on edge N+1; `trig` goes high after edge N+1 and lasts exactly one clk cycle.
  - `trig` is never high while clken = 0.
  - Latency from the qualifying sample edge: 2 clken cycles.
- Arithmetic: all compares run in ADC_WIDTH+1 signed. `level - hysteresis` and `level + hysteresis` must not overflow.
- Rising edge:
  - Pre-condition flag sets when sample < level - hysteresis.
  - Crossing = flag set AND sample >= level.
- Falling edge (mirrored):
  - Pre-condition flag sets when sample > level + hysteresis.
  - Crossing = flag set AND sample <= level.
- Flag clears on every entry to ARMED, so the pre-condition must be seen after arming.
- FSM states: IDLE, ARMED, HOLDOFF.
  - IDLE → ARMED when mode = 1 and `arm` is high.
  - IDLE → ARMED when mode = 2; no `arm` is needed.
  - ARMED, on crossing or force → pulse `trig` and increment `trig_count`.
    - mode 1: → IDLE.
    - mode 2: → HOLDOFF with counter loaded from `holdoff`.
  - HOLDOFF:
    - Counts down on clken.
    - Lasts max(holdoff, 1) clken cycles, then → ARMED.
    - Crossings and force are ignored.
- `force_trig`:
  - Honoured in ARMED and in IDLE when mode ∈ {1, 2}.
  - Same state transitions as a real crossing.
  - In IDLE with simultaneous `arm`, force wins and `arm` is discarded.
- mode written to 0 or 3 in any state: → IDLE on the next clken edge. No `trig` that cycle; holdoff is aborted.
- Crossing and force in the same cycle: exactly one pulse, one count.
- `edge`, `level` or `hysteresis` changed while ARMED: flag clears and the pre-condition must be re-observed.
- `trig_count` wraps from 0xFFFFFFFF to 0.
- clken low: state, counters and flag frozen.

Optional Feature:
- Macro: ADC_LEVEL_TRIGGER_TIMESTAMP_EN.
- Defined:
  - Adds output `trig_timestamp` [TS_WIDTH]: a free-running clken-cycle counter, reset to 0, that wraps.
  - Value is latched on the cycle `trig` asserts; holds until the next trigger; reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package adc_level_trigger_pkg holds:
  - FSM state enum (IDLE, ARMED, HOLDOFF).
  - Mode constants MODE_OFF, MODE_SINGLE, MODE_NORMAL.
  - Edge constants EDGE_RISING, EDGE_FALLING.
- Sub-module level_crossing_detector: registered sample, widened compares, pre-condition flag with clear input, one-bit crossing output. FSM, holdoff and counters stay in the top.

Test Plan:
- Rising edge: mode = 1, level = 1000, hysteresis = 100, `arm` pulse, ramp −500 → 2000 step 50 → one `trig` 2 cycles after first sample ≥ 1000; `trig_count` = 1; `armed` drops; a second ramp gives no `trig`.
- Hysteresis: ARMED, rising, level = 0, hysteresis = 200, samples oscillate between −100 and +100 → no `trig`; one sample at −250, then +10 → `trig`.
- Normal mode with holdoff: mode = 2, holdoff = 20, square wave crossing every 5 cycles → consecutive `trig` pulses ≥ 21 cycles apart; holdoff = 0 → rearm after 1 cycle.
- Force: IDLE, mode = 1, `force_trig` and `arm` in the same cycle → one `trig`, state IDLE, count +1. In HOLDOFF, `force_trig` → ignored.
- clken and mode abort: clken low on the trigger cycle → `trig` deferred to the next clken-high cycle. In HOLDOFF, mode set to 0 → IDLE, no `trig`. resetn pulled low mid-HOLDOFF → all outputs 0 immediately.
- Timestamp (macro defined): first `trig` at clken cycle 37 → `trig_timestamp` = 37, held until the next `trig`.

Source files
------------

// File: rtl/adc_level_trigger_pkg.sv
// Shared types and constants for the ADC level trigger: FSM states,
// mode encodings and edge-select encodings.
package adc_level_trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } trig_state_e;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_NORMAL = 2'd2;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

  function automatic logic mode_is_active(input logic [1:0] mode);
    logic active;
    case (mode)
      MODE_SINGLE, MODE_NORMAL: active = 1'b1;
      MODE_OFF:                 active = 1'b0;
      default:                  active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/adc_level_trigger_detector.sv
// Level-crossing detector: registers the ADC sample and tracks the hysteresis
// pre-condition flag that qualifies a rising or falling crossing of level.
module level_crossing_detector
  import adc_level_trigger_pkg::*;
#(
  parameter int ADC_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        clken,
  input  logic signed [ADC_WIDTH-1:0] adc_data,
  input  logic signed [ADC_WIDTH-1:0] level,
  input  logic        [ADC_WIDTH-2:0] hysteresis,
  input  logic                        edge_sel,
  input  logic                        clear,
  output logic                        crossing
);

  localparam int CW = ADC_WIDTH + 1;

  function automatic logic signed [CW-1:0] widen_signed(input logic [ADC_WIDTH-1:0] v);
    return $signed({v[ADC_WIDTH-1], v});
  endfunction

  function automatic logic signed [CW-1:0] widen_unsigned(input logic [ADC_WIDTH-2:0] v);
    return $signed({2'b00, v});
  endfunction

  logic signed [ADC_WIDTH-1:0] sample_r;
  logic signed [ADC_WIDTH-1:0] level_r;
  logic        [ADC_WIDTH-2:0] hyst_r;
  logic                        edge_r;
  logic                        flag_r;

  logic signed [CW-1:0] sample_w_s;
  logic signed [CW-1:0] level_w_s;
  logic signed [CW-1:0] band_lo_s;
  logic signed [CW-1:0] band_hi_s;
  logic                 pre_s;
  logic                 beyond_s;
  logic                 cfg_change_s;

  // Widened threshold compares; one extra bit keeps level +/- hysteresis exact
  always_comb begin
    sample_w_s   = widen_signed(sample_r);
    level_w_s    = widen_signed(level);
    band_lo_s    = level_w_s - widen_unsigned(hysteresis);
    band_hi_s    = level_w_s + widen_unsigned(hysteresis);
    cfg_change_s = (level != level_r) || (hysteresis != hyst_r) || (edge_sel != edge_r);
    case (edge_sel)
      EDGE_RISING: begin
        pre_s    = sample_w_s <  band_lo_s;
        beyond_s = sample_w_s >= level_w_s;
      end
      EDGE_FALLING: begin
        pre_s    = sample_w_s >  band_hi_s;
        beyond_s = sample_w_s <= level_w_s;
      end
      default: begin
        pre_s    = 1'b0;
        beyond_s = 1'b0;
      end
    endcase
    crossing = flag_r && beyond_s && !cfg_change_s;
  end

  // Sample register, settings snapshot and pre-condition flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sample_r <= '0;
      level_r  <= '0;
      hyst_r   <= '0;
      edge_r   <= 1'b0;
      flag_r   <= 1'b0;
    end else if (clken) begin
      sample_r <= adc_data;
      level_r  <= level;
      hyst_r   <= hysteresis;
      edge_r   <= edge_sel;
      if (clear || cfg_change_s) begin
        flag_r <= 1'b0;
      end else if (pre_s) begin
        flag_r <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_level_trigger.sv
// ADC level trigger: arms, detects a level crossing and issues a one-cycle trig.
// Optional timestamp output is enabled with `define ADC_LEVEL_TRIGGER_TIMESTAMP_EN.
module adc_level_trigger
  import adc_level_trigger_pkg::*;
#(
  parameter int ADC_WIDTH     = 16,
  parameter int HOLDOFF_WIDTH = 16,
  parameter int TS_WIDTH      = 48
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        clken,
  input  logic signed [ADC_WIDTH-1:0] adc_data,
  input  logic signed [ADC_WIDTH-1:0] level,
  input  logic        [ADC_WIDTH-2:0] hysteresis,
  input  logic                        edge_sel,
  input  logic        [1:0]           mode,
  input  logic                        arm,
  input  logic                        force_trig,
  input  logic [HOLDOFF_WIDTH-1:0]    holdoff,
  output logic                        trig,
  output logic                        armed,
  output logic [31:0]                 trig_count
`ifdef ADC_LEVEL_TRIGGER_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]         trig_timestamp
`endif
);

  trig_state_e              state_r;
  logic [HOLDOFF_WIDTH-1:0] holdoff_cnt_r;
  logic                     trig_r;
  logic                     armed_r;
  logic [31:0]              trig_count_r;

  logic mode_active_s;
  logic fire_s;
  logic rearm_s;
  logic crossing_s;

  level_crossing_detector #(
    .ADC_WIDTH (ADC_WIDTH)
  ) u_detector (
    .clk        (clk),
    .resetn     (resetn),
    .clken      (clken),
    .adc_data   (adc_data),
    .level      (level),
    .hysteresis (hysteresis),
    .edge_sel   (edge_sel),
    .clear      (rearm_s),
    .crossing   (crossing_s)
  );

  // Fire and re-arm decisions; force wins over arm in IDLE
  always_comb begin
    mode_active_s = mode_is_active(mode);
    fire_s        = 1'b0;
    rearm_s       = 1'b0;
    if (mode_active_s) begin
      case (state_r)
        ST_IDLE: begin
          fire_s  = force_trig;
          rearm_s = !force_trig && ((mode == MODE_NORMAL) || arm);
        end
        ST_ARMED: begin
          fire_s  = crossing_s || force_trig;
          rearm_s = 1'b0;
        end
        ST_HOLDOFF: begin
          fire_s  = 1'b0;
          rearm_s = (holdoff_cnt_r <= HOLDOFF_WIDTH'(1));
        end
        default: begin
          fire_s  = 1'b0;
          rearm_s = 1'b0;
        end
      endcase
    end else begin
      fire_s  = 1'b0;
      rearm_s = 1'b0;
    end
  end

  // Trigger FSM with registered trig, armed and trigger count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      holdoff_cnt_r <= '0;
      trig_r        <= 1'b0;
      armed_r       <= 1'b0;
      trig_count_r  <= '0;
    end else if (clken) begin
      trig_r <= fire_s;
      if (fire_s) begin
        trig_count_r <= trig_count_r + 32'd1;
      end
      if (!mode_active_s) begin
        state_r       <= ST_IDLE;
        armed_r       <= 1'b0;
        holdoff_cnt_r <= '0;
      end else if (fire_s) begin
        armed_r <= 1'b0;
        if (mode == MODE_NORMAL) begin
          state_r       <= ST_HOLDOFF;
          holdoff_cnt_r <= holdoff;
        end else begin
          state_r <= ST_IDLE;
        end
      end else if (rearm_s) begin
        state_r       <= ST_ARMED;
        armed_r       <= 1'b1;
        holdoff_cnt_r <= '0;
      end else begin
        case (state_r)
          ST_HOLDOFF:        holdoff_cnt_r <= holdoff_cnt_r - HOLDOFF_WIDTH'(1);
          ST_IDLE, ST_ARMED: state_r <= state_r;
          default: begin
            state_r <= ST_IDLE;
            armed_r <= 1'b0;
          end
        endcase
      end
    end else begin
      trig_r <= 1'b0;
    end
  end

  assign trig       = trig_r;
  assign armed      = armed_r;
  assign trig_count = trig_count_r;

`ifdef ADC_LEVEL_TRIGGER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_r;
  logic [TS_WIDTH-1:0] ts_latch_r;

  // Free-running clken-cycle counter, captured when a trigger fires
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ts_cnt_r   <= '0;
      ts_latch_r <= '0;
    end else if (clken) begin
      ts_cnt_r <= ts_cnt_r + TS_WIDTH'(1);
      if (fire_s) begin
        ts_latch_r <= ts_cnt_r;
      end
    end
  end

  assign trig_timestamp = ts_latch_r;
`else
  if (TS_WIDTH < 1) begin : g_ts_width_unused
  end
`endif

endmodule
